rx_timer: RTL
=============

RX_TIMER -- requirements
Module: rx_timer

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL provide port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port enable_timer, input, 1, receive-timing request from the receiver control unit; level-sensitive.
REQ-004 SHALL provide port data_size, input, 4, data bits per frame; legal values 5..8.
REQ-005 SHALL provide port bit_period, input, 14, clocks per serial bit.
REQ-006 SHALL provide port shift_strobe, output, 1, one-clock pulse at each bit sample point; drives the shift register.
REQ-007 SHALL provide port packet_done, output, 1, one-clock pulse after the final (stop) bit sample.

Function
REQ-008 SHALL implement states IDLE, HALF, BIT, DONE.
REQ-009 SHALL define cycle 0 as the rising edge at which IDLE samples enable_timer=1.
REQ-010 At cycle 0, SHALL latch data_size and bit_period and enter HALF.
REQ-011 Input changes after cycle 0 SHALL be ignored until the next IDLE exit.
REQ-012 Clamp rules: latched bit_period < 4 SHALL be treated as 4; data_size outside 5..8 SHALL be treated as 8.
REQ-013 HALF SHALL wait floor(P/2) clocks, where P is the clamped period, then enter BIT.
REQ-014 Strobe timing: shift_strobe SHALL be high for exactly one clock at cycle floor(P/2)+k·P, for k=1..N.
REQ-015 Frame length: N SHALL equal D+1 (data bits plus stop bit), where D is the clamped size.
REQ-016 packet_done SHALL be high for exactly one clock at the cycle after strobe N, then the block SHALL enter DONE.
REQ-017 shift_strobe and packet_done SHALL never be high in the same cycle.
REQ-018 DONE SHALL hold both outputs low and return to IDLE on the first cycle enable_timer=0.
REQ-019 DONE SHALL never restart while enable_timer remains high.
REQ-020 Abort: enable_timer=0 in HALF or BIT SHALL force IDLE on the next edge, with no further strobe and no packet_done.
REQ-021 Abort when enable_timer falls on a strobe cycle: that strobe SHALL still be emitted.
REQ-022 Both outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-023 The bit-period counter SHALL be 14 bits wide.
REQ-024 The bit-index counter SHALL be 4 bits wide.
REQ-025 Neither counter SHALL wrap within a frame.

Reset
REQ-026 On n_rst=0, SHALL asynchronously enter IDLE.
REQ-027 On n_rst=0, SHALL clear both counters and the latched configuration.
REQ-028 On n_rst=0, SHALL drive shift_strobe=0 and packet_done=0.
REQ-029 Reset mid-frame SHALL discard the frame; after release, the block SHALL wait for a fresh enable_timer=1 in IDLE.

Configuration
REQ-030 Macro RX_TIMER_PARITY_EN SHALL select the frame length.
REQ-031 With RX_TIMER_PARITY_EN defined: N = D+2 (data + parity + stop).
REQ-032 With RX_TIMER_PARITY_EN undefined: N = D+1; no parity logic or parity timing is present.

Structure
REQ-033 Shared package rx_pkg SHALL hold the timer state enum.
REQ-034 rx_pkg SHALL hold the constant MIN_BIT_PERIOD=4.
REQ-035 rx_pkg SHALL hold the constant DEFAULT_DATA_SIZE=8.
REQ-036 Counting SHALL use two instances of sub-module flex_counter (parameter NUM_CNT_BITS, inputs clear/count_enable/rollover_val, output rollover_flag): one 14-bit period counter and one 4-bit bit counter.

Verification
REQ-037 Nominal frame: P=10, size=8, no parity -> strobes at cycles 15,25,...,95 (9 strobes); packet_done at 96.
REQ-038 Minimum frame: P=4, size=5 -> strobes at 6,10,...,26 (6 strobes); packet_done at 27.
REQ-039 Clamp: P=2, size=12 -> identical timing to P=4, size=8 (strobes 6..38, done 39).
REQ-040 Abort: P=10, size=8, enable_timer dropped at cycle 40 -> strobes at 15, 25, 35 only; no packet_done; IDLE at 41.
REQ-041 Parity: RX_TIMER_PARITY_EN defined, P=10, size=8 -> 10 strobes, the last at 105; packet_done at 106.
REQ-042 Reset and hold: n_rst pulsed at cycle 30 of a P=10 frame -> outputs 0 immediately, no further pulses; DONE held while enable_timer stays high until cleared.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types, constants and clamp helpers for the receive bit timer.
// Build option RX_TIMER_PARITY_EN adds a parity bit slot to every frame.
package rx_pkg;

  typedef enum logic [1:0] {IDLE, HALF, BIT, DONE} timer_state_e;

  localparam logic [13:0] MIN_BIT_PERIOD    = 14'd4;
  localparam logic [3:0]  DEFAULT_DATA_SIZE = 4'd8;
  localparam logic [3:0]  MIN_DATA_SIZE     = 4'd5;
  localparam logic [3:0]  MAX_DATA_SIZE     = 4'd8;

  function automatic logic [13:0] clamp_period(input logic [13:0] p);
    return (p < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : p;
  endfunction

  function automatic logic [3:0] clamp_size(input logic [3:0] d);
    return ((d < MIN_DATA_SIZE) || (d > MAX_DATA_SIZE)) ? DEFAULT_DATA_SIZE : d;
  endfunction

  // Sample points per frame: data bits, optional parity, stop bit.
  function automatic logic [3:0] frame_bits(input logic [3:0] d);
`ifdef RX_TIMER_PARITY_EN
    return d + 4'd2;
`else
    return d + 4'd1;
`endif
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter that wraps to zero after reaching rollover_val.
// rollover_flag is high while the count sits at rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // NOTE: default assignment first so every path drives count_d; no latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_timer.sv
// Receive bit timer: pulses shift_strobe at mid-bit sample points, then packet_done.
// Build option RX_TIMER_PARITY_EN (see rx_pkg) lengthens each frame by a parity bit.
module rx_timer
  import rx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable_timer,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  output logic        shift_strobe,
  output logic        packet_done
);

  timer_state_e state_q, state_d;
  logic [13:0]  period_q, period_d;
  logic [3:0]   size_q, size_d;
  logic         strobe_q, strobe_d;
  logic         done_q, done_d;

  logic         cnt_clear;
  logic         period_en;
  logic         period_flag;
  logic [13:0]  period_rollover;
  logic         bit_en;
  logic         bit_flag;
  logic [3:0]   bit_rollover;

  assign cnt_clear = (state_q == IDLE) || (state_q == DONE);
  assign period_en = (state_q == HALF) || (state_q == BIT);
  // HALF spans P/2 clocks so each BIT rollover lands in the middle of a bit.
  assign period_rollover = (state_q == HALF) ? (period_q >> 1) - 14'd1
                                             : period_q - 14'd1;
  assign bit_en       = (state_q == BIT) && period_flag;
  assign bit_rollover = frame_bits(size_q) - 4'd1;

  flex_counter #(.NUM_CNT_BITS(14)) u_period_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (period_en),
    .rollover_val (period_rollover),
    .rollover_flag(period_flag)
  );

  flex_counter #(.NUM_CNT_BITS(4)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (bit_en),
    .rollover_val (bit_rollover),
    .rollover_flag(bit_flag)
  );

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    size_d   = size_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_timer) begin
          state_d  = HALF;
          period_d = clamp_period(bit_period);
          size_d   = clamp_size(data_size);
        end
      end
      HALF: begin
        if (!enable_timer)   state_d = IDLE;
        else if (period_flag) state_d = BIT;
      end
      BIT: begin
        // A strobe falling on the abort edge is still delivered.
        strobe_d = period_flag;
        if (!enable_timer)                state_d = IDLE;
        else if (period_flag && bit_flag) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle follows the final strobe; flag completion then.
        done_d = strobe_q;
        if (!enable_timer) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      size_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign shift_strobe = strobe_q;
  assign packet_done  = done_q;

endmodule
